// File: rtl/capacitive_touch_scanner.sv
// Capacitive pad scanner: charges all pads, times each discharge,
// and debounces long discharges into touch bits with sticky events.
module capacitive_touch_scanner #(
  parameter int NUM_SENSORS   = 9,
  parameter int CNT_W         = 12,
  parameter int CHARGE_CYCLES = 500,
  parameter int THRESHOLD     = 200,
  parameter int TIMEOUT       = 4095,
  parameter int DEBOUNCE      = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] capacitive_sensors_in,
  output logic                   capacitive_sensors_out,
  output logic [NUM_SENSORS-1:0] touch_state,
  output logic [NUM_SENSORS-1:0] touch_latched,
  input  logic                   clear_en,
  input  logic [NUM_SENSORS-1:0] clear_mask,
  output logic                   scan_done,
  input  logic [3:0]             count_sel,
  output logic [CNT_W-1:0]       count_q
);

  localparam int CHG_W = $clog2(CHARGE_CYCLES + 1);
  localparam int DB_W  = $clog2(DEBOUNCE + 1);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);
  localparam logic [CHG_W-1:0] CHG_LAST = CHG_W'(CHARGE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHARGE,
    S_MEASURE,
    S_EVAL
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                   r_out;
  logic                   r_done;
  logic                   w_out;
  logic                   w_done;
  logic [NUM_SENSORS-1:0] r_sync1;
  logic [NUM_SENSORS-1:0] r_sync2;
  logic [CHG_W-1:0]       r_chg;
  logic [CNT_W-1:0]       r_timer;
  logic [CNT_W-1:0]       r_cnt [NUM_SENSORS];
  logic [CNT_W-1:0]       r_pub [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] r_lat;
  logic [DB_W-1:0]        r_db  [NUM_SENSORS];
  logic [DB_W-1:0]        w_db_next [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] r_ts;
  logic [NUM_SENSORS-1:0] r_tl;
  logic [NUM_SENSORS-1:0] w_ts_next;
  logic [NUM_SENSORS-1:0] w_raw;
  logic [NUM_SENSORS-1:0] w_hit;
  logic [NUM_SENSORS-1:0] w_rise;
  logic [NUM_SENSORS-1:0] w_clr;
  logic                   w_all;
  logic                   w_tmo;
  logic                   w_chg_end;
  logic                   w_meas;
  logic                   w_eval;

  assign w_meas    = (r_state == S_MEASURE);
  assign w_eval    = (r_state == S_EVAL);
  assign w_tmo     = (r_timer == TMO);
  assign w_chg_end = (r_chg == CHG_LAST);

  // A pad counts as done if latched earlier or discharging this cycle
  assign w_hit = r_lat | ~r_sync2;
  assign w_all = &w_hit;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (enable) w_next = S_CHARGE;
      S_CHARGE:  if (w_chg_end) w_next = S_MEASURE;
      S_MEASURE: if (w_all || w_tmo) w_next = S_EVAL;
      S_EVAL:    w_next = enable ? S_CHARGE : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    w_out  = (w_next == S_CHARGE);
    w_done = (w_next == S_EVAL);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_out   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_out   <= w_out;
      r_done  <= w_done;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= capacitive_sensors_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_chg <= '0;
    end else if (r_state == S_CHARGE) begin
      r_chg <= r_chg + 1'b1;
    end else begin
      r_chg <= '0;
    end
  end

  // Timer saturates at the timeout value instead of wrapping
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_timer <= '0;
    end else if (w_meas) begin
      if (!w_tmo) r_timer <= r_timer + 1'b1;
    end else begin
      r_timer <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lat <= '0;
      for (int i = 0; i < NUM_SENSORS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SENSORS; i++) begin
        if (r_state == S_CHARGE) begin
          r_lat[i] <= 1'b0;
        end else if (w_meas && !r_lat[i]) begin
          if (!r_sync2[i]) begin
            r_cnt[i] <= r_timer;
            r_lat[i] <= 1'b1;
          end else if (w_tmo) begin
            r_cnt[i] <= TMO;
            r_lat[i] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_ts_next = r_ts;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      w_raw[i]     = (r_cnt[i] >= THR);
      w_db_next[i] = r_db[i];
      if (w_eval) begin
        if (w_raw[i] == r_ts[i]) begin
          w_db_next[i] = '0;
        end else if (r_db[i] == DB_LAST) begin
          w_db_next[i] = '0;
          w_ts_next[i] = ~r_ts[i];
        end else begin
          w_db_next[i] = r_db[i] + 1'b1;
        end
      end
    end
  end

  assign w_rise = w_ts_next & ~r_ts;
  assign w_clr  = clear_en ? clear_mask : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ts <= '0;
      r_tl <= '0;
      for (int i = 0; i < NUM_SENSORS; i++) begin
        r_db[i]  <= '0;
        r_pub[i] <= '0;
      end
    end else begin
      r_ts <= w_ts_next;
      r_tl <= (r_tl & ~w_clr) | w_rise;
      for (int i = 0; i < NUM_SENSORS; i++) begin
        r_db[i] <= w_db_next[i];
        if (w_eval) r_pub[i] <= r_cnt[i];
      end
    end
  end

  always_comb begin
    count_q = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (count_sel == 4'(i)) count_q = r_pub[i];
    end
  end

  assign capacitive_sensors_out = r_out;
  assign scan_done              = r_done;
  assign touch_state            = r_ts;
  assign touch_latched          = r_tl;

endmodule
